// File: rtl/gfx_pkg.sv
// gfx_pkg
// Shared definitions for the framebuffer write path:
//   - DEF_FB_WIDTH / DEF_FB_HEIGHT : default framebuffer geometry in pixels
//   - wr_state_e                   : writer FSM states
//   - pixel_t                      : one buffered pixel {sx, sy, color, last}
//   - pixel_addr()                 : linear framebuffer address sy*width+sx, 15 bits
package gfx_pkg;

    localparam int DEF_FB_WIDTH  = 160;
    localparam int DEF_FB_HEIGHT = 120;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_WRITE = 1'b1
    } wr_state_e;

    typedef struct packed {
        logic [7:0]  sx;
        logic [6:0]  sy;
        logic [11:0] color;
        logic        last;
    } pixel_t;

    // Full-width product first, then keep the low 15 bits as the memory address.
    function automatic logic [14:0] pixel_addr(input logic [7:0]  sx,
                                               input logic [6:0]  sy,
                                               input logic [31:0] width);
        logic [31:0] lin;
        lin = {25'd0, sy} * width + {24'd0, sx};
        return lin[14:0];
    endfunction

endpackage

// File: rtl/pixel_fifo.sv
// pixel_fifo
// Synchronous first-word-fall-through FIFO of pixel_t entries.
// Ports:
//   clk, rst_n   : clock, asynchronous active-low reset (empties the FIFO)
//   push, din    : write an entry (ignored when full)
//   pop, dout    : consume the head entry (ignored when empty); dout shows the head
//   full, empty  : occupancy flags
module pixel_fifo
    import gfx_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic   clk,
    input  logic   rst_n,
    input  logic   push,
    input  pixel_t din,
    input  logic   pop,
    output pixel_t dout,
    output logic   full,
    output logic   empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    pixel_t          store [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [AW:0]     count;
    logic            push_ok;
    logic            pop_ok;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign dout    = store[rd_ptr];

    // Storage needs no reset: an entry is only ever read after it was written.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            store[wr_ptr] <= din;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/fb_writer.sv
// fb_writer
// Accepts a stream of drawn pixels, buffers them, and commits each one as a
// single write to framebuffer memory. Off-screen pixels are dropped.
// Ports:
//   clk, rst_n                  : clock, asynchronous active-low reset
//   in_valid/in_ready           : pixel handshake, in_ready = FIFO not full
//   in_sx, in_sy, in_color      : pixel coordinates and RGB444 colour
//   in_last                     : final pixel of a primitive
//   mem_we/mem_addr/mem_wdata   : write request, held until mem_ack
//   mem_ack                     : memory takes the write this cycle
//   done                        : one-cycle pulse when a primitive is fully committed
//   clip_cnt                    : saturating count of dropped off-screen pixels
// Configuration macro:
//   FB_WRITER_CLIP_COUNT_EN     : when defined, clip_cnt counts; otherwise it is tied to 0
module fb_writer
    import gfx_pkg::*;
#(
    parameter int FB_WIDTH   = DEF_FB_WIDTH,
    parameter int FB_HEIGHT  = DEF_FB_HEIGHT,
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [7:0]  in_sx,
    input  logic [6:0]  in_sy,
    input  logic [11:0] in_color,
    input  logic        in_last,
    output logic        mem_we,
    output logic [14:0] mem_addr,
    output logic [11:0] mem_wdata,
    input  logic        mem_ack,
    output logic        done,
    output logic [15:0] clip_cnt
);

    localparam logic [31:0] FBW = 32'(FB_WIDTH);
    localparam logic [31:0] FBH = 32'(FB_HEIGHT);

    wr_state_e state;
    pixel_t    in_px;
    pixel_t    head;
    logic      fifo_full;
    logic      fifo_empty;
    logic      push;
    logic      pop;
    logic      head_clip;
    logic      cur_last;
    logic      rdy_en;

    assign in_px     = '{sx: in_sx, sy: in_sy, color: in_color, last: in_last};
    assign in_ready  = rdy_en && !fifo_full;
    assign push      = in_valid && in_ready;
    // The head leaves the FIFO whenever the write slot is free or being freed this cycle.
    assign pop       = !fifo_empty && ((state == ST_IDLE) || mem_ack);
    assign head_clip = ({24'd0, head.sx} >= FBW) || ({25'd0, head.sy} >= FBH);

    pixel_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .din   (in_px),
        .pop   (pop),
        .dout  (head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Keeps in_ready low during reset and raises it on the first edge afterwards.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdy_en <= 1'b0;
        end else begin
            rdy_en <= 1'b1;
        end
    end

    // Writer FSM. A pop either loads a new write (staying in or entering WRITE)
    // or, for an off-screen pixel, leaves the slot empty and falls back to IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            done      <= 1'b0;
            cur_last  <= 1'b0;
        end else begin
            done <= 1'b0;
            if (state == ST_WRITE && mem_ack && cur_last) begin
                done <= 1'b1;
            end
            if (pop) begin
                if (head_clip) begin
                    state  <= ST_IDLE;
                    mem_we <= 1'b0;
                    if (head.last) begin
                        done <= 1'b1;
                    end
                end else begin
                    state     <= ST_WRITE;
                    mem_we    <= 1'b1;
                    mem_addr  <= pixel_addr(head.sx, head.sy, FBW);
                    mem_wdata <= head.color;
                    cur_last  <= head.last;
                end
            end else if (state == ST_WRITE && mem_ack) begin
                state  <= ST_IDLE;
                mem_we <= 1'b0;
            end
        end
    end

`ifdef FB_WRITER_CLIP_COUNT_EN
    logic [15:0] clip_q;

    // Counts every dropped pixel, sticking at all-ones.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clip_q <= '0;
        end else if (pop && head_clip && (clip_q != 16'hFFFF)) begin
            clip_q <= clip_q + 16'd1;
        end
    end

    assign clip_cnt = clip_q;
`else
    assign clip_cnt = 16'd0;
`endif

endmodule

// File: tb/tb_fb_writer.sv
// tb_fb_writer
// Self-checking bench for fb_writer. A monitor keeps an ordered list of the
// writes each accepted pixel must produce (address, colour, last) and checks
// every memory handshake against it, plus hold-while-stalled and done timing.
// Directed tests pin concrete values: single pixel latency, a 90-pixel row,
// back-pressure with a stalled memory, clipping, and reset during a write.
module tb_fb_writer;

    localparam int W = 160;
    localparam int H = 120;
`ifdef FB_WRITER_CLIP_COUNT_EN
    localparam int CLIP_ON = 1;
`else
    localparam int CLIP_ON = 0;
`endif

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_sx;
    logic [6:0]  in_sy;
    logic [11:0] in_color;
    logic        in_last;
    logic        mem_we;
    logic [14:0] mem_addr;
    logic [11:0] mem_wdata;
    logic        mem_ack;
    logic        done;
    logic [15:0] clip_cnt;

    int checks   = 0;
    int failures = 0;

    int exp_addr[$];
    int exp_data[$];
    bit exp_last[$];
    int clip_model;
    int done_exp;
    int done_seen;
    int writes_seen;
    int run_len;
    int max_run;
    int first_addr;
    int last_addr;
    bit done_due;
    bit hold_pending;
    logic [14:0] hold_addr;
    logic [11:0] hold_data;

    fb_writer #(
        .FB_WIDTH   (W),
        .FB_HEIGHT  (H),
        .FIFO_DEPTH (4)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_sx     (in_sx),
        .in_sy     (in_sy),
        .in_color  (in_color),
        .in_last   (in_last),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_ack   (mem_ack),
        .done      (done),
        .clip_cnt  (clip_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%0d expected=%0d", name, actual, expected);
        end
    endtask

    task automatic waitCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic waitCycles(input int n);
        for (int i = 0; i < n; i++) begin
            waitCycle();
        end
    endtask

    // Offers one pixel and holds it until the DUT takes it.
    task automatic applyStimulus(input int sx, input int sy, input int color, input bit last);
        bit acc;
        in_sx    = 8'(sx);
        in_sy    = 7'(sy);
        in_color = 12'(color);
        in_last  = last;
        in_valid = 1'b1;
        for (int i = 0; i < 100; i++) begin
            acc = in_ready;
            waitCycle();
            if (acc) begin
                in_valid = 1'b0;
                return;
            end
        end
        in_valid = 1'b0;
        checkOutput("accept_timeout", 32'd0, 32'd1);
    endtask

    task automatic drain();
        for (int i = 0; i < 300; i++) begin
            if (exp_addr.size() == 0 && !mem_we) begin
                waitCycles(4);
                return;
            end
            waitCycle();
        end
        checkOutput("drain_timeout", 32'd0, 32'd1);
    endtask

    task automatic clearCounters();
        done_exp    = 0;
        done_seen   = 0;
        writes_seen = 0;
        max_run     = 0;
        first_addr  = -1;
        last_addr   = -1;
    endtask

    // Reference monitor: accepted pixels become expected writes or clips.
    always @(negedge clk) begin
        if (!rst_n) begin
            exp_addr.delete();
            exp_data.delete();
            exp_last.delete();
            clip_model   = 0;
            done_due     = 1'b0;
            hold_pending = 1'b0;
            run_len      = 0;
        end else begin
            if (done_due) begin
                checkOutput("done_after_last", 32'(done), 32'd1);
                done_due = 1'b0;
            end
            if (done === 1'b1) begin
                done_seen++;
            end
            if (hold_pending) begin
                checkOutput("we_hold", 32'(mem_we), 32'd1);
                checkOutput("addr_hold", 32'(mem_addr), 32'(hold_addr));
                checkOutput("data_hold", 32'(mem_wdata), 32'(hold_data));
            end
            if (in_valid && in_ready) begin
                if (last_flag_of_accept()) begin
                    done_exp++;
                end
                if (int'(in_sx) >= W || int'(in_sy) >= H) begin
                    clip_model++;
                end else begin
                    exp_addr.push_back(int'(in_sy) * W + int'(in_sx));
                    exp_data.push_back(int'(in_color));
                    exp_last.push_back(in_last);
                end
            end
            if (mem_we && mem_ack) begin
                writes_seen++;
                run_len++;
                if (run_len > max_run) max_run = run_len;
                if (first_addr < 0) first_addr = int'(mem_addr);
                last_addr = int'(mem_addr);
                if (exp_addr.size() == 0) begin
                    checkOutput("spurious_write", 32'd1, 32'd0);
                end else begin
                    int  a;
                    int  d;
                    bit  l;
                    a = exp_addr.pop_front();
                    d = exp_data.pop_front();
                    l = exp_last.pop_front();
                    checkOutput("write_addr", 32'(mem_addr), 32'(a));
                    checkOutput("write_data", 32'(mem_wdata), 32'(d));
                    if (l) done_due = 1'b1;
                end
            end else begin
                run_len = 0;
            end
            hold_pending = mem_we && !mem_ack;
            hold_addr    = mem_addr;
            hold_data    = mem_wdata;
        end
    end

    function automatic bit last_flag_of_accept();
        return in_last;
    endfunction

    initial begin
        #200000;
        $display("[TB] FAIL watchdog actual=timeout required=finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int idx;
        bit acc;
        int bx[8];
        int by[8];

        rst_n    = 1'b1;
        in_valid = 1'b0;
        in_sx    = '0;
        in_sy    = '0;
        in_color = '0;
        in_last  = 1'b0;
        mem_ack  = 1'b0;
        clearCounters();
        #2 rst_n = 1'b0;
        #2;

        // Reset state.
        checkOutput("rst_in_ready", 32'(in_ready), 32'd0);
        checkOutput("rst_mem_we", 32'(mem_we), 32'd0);
        checkOutput("rst_mem_addr", 32'(mem_addr), 32'd0);
        checkOutput("rst_mem_wdata", 32'(mem_wdata), 32'd0);
        checkOutput("rst_done", 32'(done), 32'd0);
        checkOutput("rst_clip_cnt", 32'(clip_cnt), 32'd0);
        waitCycles(3);
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("ready_before_edge", 32'(in_ready), 32'd0);
        waitCycle();
        checkOutput("ready_after_edge", 32'(in_ready), 32'd1);

        // Single pixel latency and address.
        $display("[TB] single pixel");
        clearCounters();
        mem_ack = 1'b1;
        applyStimulus(10, 25, 'hfff, 1'b1);
        @(negedge clk);
        checkOutput("lat_we_cycle1", 32'(mem_we), 32'd0);
        @(negedge clk);
        checkOutput("lat_we_cycle2", 32'(mem_we), 32'd1);
        checkOutput("single_addr", 32'(mem_addr), 32'd4010);
        checkOutput("single_data", 32'(mem_wdata), 32'hfff);
        @(negedge clk);
        checkOutput("single_done", 32'(done), 32'd1);
        checkOutput("single_we_off", 32'(mem_we), 32'd0);
        waitCycles(3);
        checkOutput("single_done_count", 32'(done_seen), 32'd1);

        // 90-pixel row at y=25.
        $display("[TB] row");
        clearCounters();
        for (int x = 10; x < 100; x++) begin
            applyStimulus(x, 25, x * 7, x == 99);
        end
        drain();
        checkOutput("row_writes", 32'(writes_seen), 32'd90);
        checkOutput("row_consecutive", 32'(max_run), 32'd90);
        checkOutput("row_first_addr", 32'(first_addr), 32'd4010);
        checkOutput("row_last_addr", 32'(last_addr), 32'd4099);
        checkOutput("row_done", 32'(done_seen), 32'd1);
        checkOutput("row_done_model", 32'(done_exp), 32'd1);

        // Back-pressure: memory stalled for 20 cycles, 8 pixels offered.
        $display("[TB] back-pressure");
        clearCounters();
        mem_ack = 1'b0;
        for (int i = 0; i < 8; i++) begin
            bx[i] = i * 3;
            by[i] = 40 + i;
        end
        idx = 0;
        for (int c = 0; c < 20; c++) begin
            if (idx < 8) begin
                in_sx    = 8'(bx[idx]);
                in_sy    = 7'(by[idx]);
                in_color = 12'('h100 + idx);
                in_last  = (idx == 7);
                in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            acc = in_valid && in_ready;
            waitCycle();
            if (acc) idx++;
        end
        checkOutput("bp_accepted", 32'(idx), 32'd5);
        checkOutput("bp_ready_low", 32'(in_ready), 32'd0);
        checkOutput("bp_no_writes", 32'(writes_seen), 32'd0);
        checkOutput("bp_we_held", 32'(mem_we), 32'd1);
        mem_ack = 1'b1;
        for (int c = 0; c < 100 && idx < 8; c++) begin
            in_sx    = 8'(bx[idx]);
            in_sy    = 7'(by[idx]);
            in_color = 12'('h100 + idx);
            in_last  = (idx == 7);
            in_valid = 1'b1;
            acc = in_ready;
            waitCycle();
            if (acc) idx++;
        end
        in_valid = 1'b0;
        checkOutput("bp_all_accepted", 32'(idx), 32'd8);
        drain();
        checkOutput("bp_writes", 32'(writes_seen), 32'd8);
        checkOutput("bp_done", 32'(done_seen), 32'd1);

        // Off-screen pixels.
        $display("[TB] clipping");
        clearCounters();
        applyStimulus(160, 0, 'h0f0, 1'b0);
        applyStimulus(0, 120, 'h0f0, 1'b0);
        waitCycles(6);
        checkOutput("clip_no_writes", 32'(writes_seen), 32'd0);
        checkOutput("clip_cnt_two", 32'(clip_cnt), 32'(2 * CLIP_ON));
        checkOutput("clip_cnt_model", 32'(clip_cnt), 32'(clip_model * CLIP_ON));
        checkOutput("clip_no_done", 32'(done_seen), 32'd0);

        // Clipped pixel closing a primitive still signals done.
        clearCounters();
        applyStimulus(200, 5, 'h123, 1'b1);
        waitCycles(6);
        checkOutput("cliplast_no_writes", 32'(writes_seen), 32'd0);
        checkOutput("cliplast_done", 32'(done_seen), 32'd1);
        checkOutput("cliplast_cnt", 32'(clip_cnt), 32'(3 * CLIP_ON));

        // Reset while a write is stalled.
        $display("[TB] reset during write");
        clearCounters();
        mem_ack = 1'b0;
        applyStimulus(5, 5, 'h321, 1'b1);
        applyStimulus(6, 5, 'h322, 1'b1);
        for (int i = 0; i < 10 && !mem_we; i++) begin
            waitCycle();
        end
        checkOutput("rw_we_before", 32'(mem_we), 32'd1);
        rst_n = 1'b0;
        #1;
        checkOutput("rw_we_drop", 32'(mem_we), 32'd0);
        checkOutput("rw_ready_low", 32'(in_ready), 32'd0);
        checkOutput("rw_addr_zero", 32'(mem_addr), 32'd0);
        checkOutput("rw_clip_zero", 32'(clip_cnt), 32'd0);
        waitCycles(2);
        rst_n   = 1'b1;
        mem_ack = 1'b1;
        waitCycles(6);
        checkOutput("rw_no_writes", 32'(writes_seen), 32'd0);
        checkOutput("rw_no_done", 32'(done_seen), 32'd0);
        checkOutput("rw_ready_back", 32'(in_ready), 32'd1);

        // Normal operation resumes after reset.
        clearCounters();
        applyStimulus(1, 1, 'habc, 1'b1);
        drain();
        checkOutput("post_rst_writes", 32'(writes_seen), 32'd1);
        checkOutput("post_rst_addr", 32'(last_addr), 32'd161);
        checkOutput("post_rst_done", 32'(done_seen), 32'd1);
        checkOutput("model_empty", 32'(exp_addr.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fb_writer.md
FB_WRITER -- requirements
Module: fb_writer

Interface
REQ-001 SHALL have parameter FB_WIDTH, default 160, framebuffer width in pixels.
REQ-002 SHALL have parameter FB_HEIGHT, default 120, framebuffer height in pixels.
REQ-003 SHALL have parameter FIFO_DEPTH, default 4, input buffer entries (power of two, >=2).
REQ-004 SHALL have port clk  input  1  sole clock; all logic on rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port in_valid  input  1  pixel offered.
REQ-007 SHALL have port in_ready  output  1  pixel accepted when in_valid && in_ready.
REQ-008 SHALL have port in_sx  input  8  pixel x.
REQ-009 SHALL have port in_sy  input  7  pixel y.
REQ-010 SHALL have port in_color  input  12  RGB444 colour.
REQ-011 SHALL have port in_last  input  1  marks final pixel of a drawn primitive.
REQ-012 SHALL have port mem_we  output  1  write request to framebuffer memory.
REQ-013 SHALL have port mem_addr  output  15  linear address sy*FB_WIDTH+sx.
REQ-014 SHALL have port mem_wdata  output  12  colour to write.
REQ-015 SHALL have port mem_ack  input  1  memory accepts the write this cycle.
REQ-016 SHALL have port done  output  1  one-cycle pulse, primitive fully committed.
REQ-017 SHALL have port clip_cnt  output  16  count of dropped out-of-range pixels.

Function
REQ-018 SHALL buffer accepted pixels {sx, sy, color, last} in a FIFO_DEPTH-entry FIFO, in order.
REQ-019 SHALL drive in_ready = !fifo_full, independent of same-cycle pop (no push when full).
REQ-020 SHALL run FSM IDLE -> WRITE -> IDLE: IDLE pops head when FIFO non-empty; WRITE holds mem_we/mem_addr/mem_wdata stable until mem_ack.
REQ-021 SHALL, on mem_ack in WRITE, pop the next entry in the same cycle if available (back-to-back, one write per cycle when mem_ack stays high), else return to IDLE.
REQ-022 SHALL, on pop of an entry with sx>=FB_WIDTH or sy>=FB_HEIGHT, issue no write, stay/return per FIFO state, and increment clip_cnt.
REQ-023 SHALL compute mem_addr as (sy*FB_WIDTH+sx) truncated to 15 bits, registered at pop.
REQ-024 SHALL give latency of 2 cycles from accept to mem_we high with an empty FIFO and idle FSM.
REQ-025 SHALL pulse done the cycle after mem_ack of an entry with last=1, or the cycle after popping a clipped entry with last=1.
REQ-026 SHALL saturate clip_cnt at 16'hFFFF.
REQ-027 SHALL keep mem_we low in IDLE; mem_addr/mem_wdata hold last value.

Reset
REQ-028 SHALL, while rst_n low, force FSM IDLE, FIFO empty, in_ready 0, mem_we 0, mem_addr 0, mem_wdata 0, done 0, clip_cnt 0.
REQ-029 SHALL abandon an in-flight write on reset assertion; mem_we drops without waiting for mem_ack, and the entry is lost.
REQ-030 SHALL raise in_ready on the first rising clk edge after rst_n deasserts.

Configuration
REQ-031 SHALL, with FB_WRITER_CLIP_COUNT_EN defined, implement clip_cnt per REQ-022/026.
REQ-032 SHALL, without FB_WRITER_CLIP_COUNT_EN, tie clip_cnt to 0 and still drop clipped pixels.

Structure
REQ-033 SHALL put FSM state enum, pixel entry struct and default FB_WIDTH/FB_HEIGHT constants in shared package gfx_pkg.
REQ-034 SHALL implement the buffer as sub-module pixel_fifo (sync FIFO, full/empty flags).

Verification
REQ-035 SHALL test: single pixel (10,25,12'hfff,last=1), mem_ack tied 1 -> mem_we 2 cycles after accept, mem_addr 4010, done next cycle.
REQ-036 SHALL test: 90-pixel row y=25 x=10..99, mem_ack=1 -> 90 consecutive writes, addresses 4010..4099, one done.
REQ-037 SHALL test: mem_ack held 0 for 20 cycles, 8 pixels offered -> in_ready low after 4 accepted plus 1 in WRITE, no loss once ack resumes.
REQ-038 SHALL test: pixels (160,0) and (0,120) -> no mem_we, clip_cnt=2; with macro undefined, clip_cnt=0.
REQ-039 SHALL test: rst_n low during WRITE with mem_ack=0 -> mem_we 0 immediately, FIFO empty, no done after release.
REQ-040 SHALL test: clipped pixel with last=1 -> done pulse without any write.
